// File: rtl/pattern_sched_if.sv
// Requester and detector signal bundle for pattern_sched.
// The slave modport is the scheduler's view; master is the requester/detector side.
interface pattern_sched_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
);
   localparam int ID_W = $clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic                  det_clr;
   logic                  det_in;
   logic                  det_out;
   logic                  busy;
   logic                  done;
   logic [ID_W-1:0]       done_id;
   logic [CNT_W-1:0]      match_cnt;

   modport slave (
      input  req, data, det_out,
      output gnt, det_clr, det_in, busy, done, done_id, match_cnt
   );

   modport master (
      output req, data, det_out,
      input  gnt, det_clr, det_in, busy, done, done_id, match_cnt
   );
endinterface

// File: rtl/pattern_sched.sv
// Time-shares one serial pattern detector among NREQ requesters (round-robin by default).
// Define PATTERN_SCHED_PRIO_EN for fixed lowest-index-wins priority.
module pattern_sched #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 16,
   parameter int DET_LAT = 1,
   parameter int CNT_W   = 5
) (
   input  logic            clk,
   input  logic            rst,
   pattern_sched_if.slave  bus
);
   localparam int ID_W = $clog2(NREQ);
   localparam int BC_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

   state_t            state, state_d;
   logic [WIDTH-1:0]  shreg, shreg_d;
   logic [BC_W-1:0]   bit_cnt, bit_cnt_d;
   logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
   logic [ID_W-1:0]   id, id_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              det_clr_q, det_clr_d;
   logic              det_in_q, det_in_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ID_W-1:0]   done_id_q, done_id_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

   logic              sample;
   logic              win_vld;
   logic              win_take;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   start;
   logic [ID_W-1:0]   idx;
   int                sum;

`ifdef PATTERN_SCHED_PRIO_EN
   assign start = '0;
`else
   logic [ID_W-1:0] ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ptr <= '0;
      else if (win_take)
         ptr <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
   end

   assign start = ptr;
`endif

   // First pending requester at or after start, wrapping modulo NREQ.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      sum     = 0;
      for (int i = 0; i < NREQ; i++) begin
         sum = int'(start) + i;
         if (sum >= NREQ) sum = sum - NREQ;
         idx = ID_W'(sum);
         if (!win_vld && bus.req[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
   end

   assign win_take = win_vld && (state == IDLE || state == DONE);

   // NOTE: every comb output gets a default first; a missed branch would otherwise infer a latch.
   always_comb begin
      state_d     = state;
      shreg_d     = shreg;
      bit_cnt_d   = bit_cnt;
      cnt_d       = cnt;
      id_d        = id;
      gnt_d       = '0;
      det_clr_d   = 1'b0;
      det_in_d    = 1'b0;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      match_cnt_d = match_cnt_q;

      // One sample per input bit: skip the first DET_LAT shift cycles, cover all of DRAIN.
      sample  = (state == SHIFT && bit_cnt >= BC_W'(DET_LAT)) || state == DRAIN;
      cnt_inc = (sample && bus.det_out && cnt != '1) ? cnt + 1'b1 : cnt;

      unique case (state)
         IDLE, DONE: begin
            if (win_vld) begin
               state_d        = CLEAR;
               gnt_d[win_id]  = 1'b1;
               det_clr_d      = 1'b1;
               shreg_d        = bus.data[int'(win_id)*WIDTH +: WIDTH];
               id_d           = win_id;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            state_d   = SHIFT;
            cnt_d     = '0;
            bit_cnt_d = '0;
            det_in_d  = shreg[WIDTH-1];
            shreg_d   = shreg << 1;
         end
         SHIFT: begin
            cnt_d = cnt_inc;
            if (bit_cnt == BC_W'(WIDTH - 1)) begin
               state_d   = DRAIN;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt + 1'b1;
               det_in_d  = shreg[WIDTH-1];
               shreg_d   = shreg << 1;
            end
         end
         DRAIN: begin
            cnt_d = cnt_inc;
            if (bit_cnt == BC_W'(DET_LAT - 1)) begin
               state_d     = DONE;
               done_d      = 1'b1;
               done_id_d   = id;
               match_cnt_d = cnt_inc;
            end else begin
               bit_cnt_d = bit_cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         cnt         <= '0;
         id          <= '0;
         gnt_q       <= '0;
         det_clr_q   <= 1'b0;
         det_in_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         match_cnt_q <= '0;
      end else begin
         state       <= state_d;
         shreg       <= shreg_d;
         bit_cnt     <= bit_cnt_d;
         cnt         <= cnt_d;
         id          <= id_d;
         gnt_q       <= gnt_d;
         det_clr_q   <= det_clr_d;
         det_in_q    <= det_in_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.det_clr   = det_clr_q;
   assign bus.det_in    = det_in_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.done_id   = done_id_q;
   assign bus.match_cnt = match_cnt_q;
endmodule
